crat_ckpt: RTL

//  CAM-style rename table (one entry per physical reg), successor to the fixed 4-wide cRAT.
//  - Generalised in rename width, physical/architectural reg count and checkpoint depth.
//  - Adds intra-group RAW/WAW bypass and a checkpoint queue that snapshots the valid vector per branch.
//  - Sits in the rename stage between decode and dispatch.
//  - Recovers either from an arch-RAT vector (full flush) or from a branch checkpoint.

---
 rtl/crat_ckpt.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/crat_ckpt.sv
// crat_ckpt: CAM-style register alias table (one entry per physical register)
// with intra-group RAW/WAW bypass and a branch checkpoint queue that
// snapshots the valid vector.
// Ports:
//   i_clock, i_reset        rising-edge clock, synchronous active-high reset
//   i_rename_en             rename group fires this cycle
//   i_rj/i_rk/i_rd          per-slot source/destination architectural regs
//   i_rd_valid              per-slot destination write enable
//   i_alloc_preg            per-slot newly allocated physical reg
//   o_prj/o_prk/o_pprd      per-slot renamed sources / previous rd mapping (comb)
//   i_ckpt_req              per-slot branch marker (at most one per group)
//   o_ckpt_ready, o_ckpt_id checkpoint slot available / id handed out (tail)
//   i_ckpt_release          free the oldest checkpoint
//   i_redirect, i_redirect_id  restore valid vector from a checkpoint
//   i_predict_fail, i_arch_rat full flush to the committed valid vector
module crat_ckpt #(
  parameter  int unsigned RW    = 4,
  parameter  int unsigned NPREG = 64,
  parameter  int unsigned NAREG = 32,
  parameter  int unsigned NCKPT = 4,
  localparam int unsigned PW    = $clog2(NPREG),
  localparam int unsigned AW    = $clog2(NAREG),
  localparam int unsigned CW    = $clog2(NCKPT)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rename_en,
  input  logic [RW-1:0][AW-1:0] i_rj,
  input  logic [RW-1:0][AW-1:0] i_rk,
  input  logic [RW-1:0][AW-1:0] i_rd,
  input  logic [RW-1:0]         i_rd_valid,
  input  logic [RW-1:0][PW-1:0] i_alloc_preg,
  output logic [RW-1:0][PW-1:0] o_prj,
  output logic [RW-1:0][PW-1:0] o_prk,
  output logic [RW-1:0][PW-1:0] o_pprd,
  input  logic [RW-1:0]         i_ckpt_req,
  output logic                  o_ckpt_ready,
  output logic [CW-1:0]         o_ckpt_id,
  input  logic                  i_ckpt_release,
  input  logic                  i_redirect,
  input  logic [CW-1:0]         i_redirect_id,
  input  logic                  i_predict_fail,
  input  logic [NPREG-1:0]      i_arch_rat
);

  logic [NPREG-1:0][AW-1:0]    r_src,   w_src_nxt;
  logic [NPREG-1:0]            r_valid, w_valid_nxt;
  logic [NCKPT-1:0][NPREG-1:0] r_snap,  w_snap_nxt;
  logic [CW-1:0]               r_head,  w_head_nxt;
  logic [CW-1:0]               r_tail,  w_tail_nxt;
  logic [CW:0]                 r_count, w_count_nxt;
  logic                        w_rel;
  logic                        w_stall;
  logic                        w_alloc;

  // Circular pointer increment that also works for non-power-of-two depths
  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(NCKPT - 1)) ? '0 : CW'(p + 1'b1);
  endfunction

  // (a - b) mod NCKPT
  function automatic logic [CW:0] ptr_dist(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + (CW+1)'(NCKPT);
    return d;
  endfunction

  assign o_ckpt_id    = r_tail;
  assign o_ckpt_ready = (r_count < (CW+1)'(NCKPT)) ||
                        ((r_count == (CW+1)'(NCKPT)) && i_ckpt_release);

  // CAM lookup (OR of hit indices), then the youngest older slot in the
  // group writing the same arch reg overrides it
  always_comb begin
    o_prj  = '0;
    o_prk  = '0;
    o_pprd = '0;
    for (int i = 0; i < int'(RW); i++) begin
      for (int k = 0; k < int'(NPREG); k++) begin
        if (r_valid[k] && (r_src[k] == i_rj[i])) o_prj[i]  = o_prj[i]  | PW'(k);
        if (r_valid[k] && (r_src[k] == i_rk[i])) o_prk[i]  = o_prk[i]  | PW'(k);
        if (r_valid[k] && (r_src[k] == i_rd[i])) o_pprd[i] = o_pprd[i] | PW'(k);
      end
      for (int j = 0; j < i; j++) begin
        if (i_rd_valid[j] && (i_rd[j] == i_rj[i])) o_prj[i]  = i_alloc_preg[j];
        if (i_rd_valid[j] && (i_rd[j] == i_rk[i])) o_prk[i]  = i_alloc_preg[j];
        if (i_rd_valid[j] && (i_rd[j] == i_rd[i])) o_pprd[i] = i_alloc_preg[j];
      end
    end
  end

  // Next-state: flush > redirect > rename; release applies unless flushing
  always_comb begin
    w_src_nxt   = r_src;
    w_valid_nxt = r_valid;
    w_snap_nxt  = r_snap;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_alloc     = 1'b0;
    w_rel       = i_ckpt_release && (r_count != '0);
    // a branch that cannot get a checkpoint holds back the whole group
    w_stall     = (|i_ckpt_req) && !o_ckpt_ready;

    if (i_predict_fail) begin
      w_valid_nxt = i_arch_rat;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (i_redirect) begin
        w_valid_nxt = r_snap[i_redirect_id];
        w_tail_nxt  = ptr_inc(i_redirect_id);
        w_count_nxt = ptr_dist(i_redirect_id, r_head) + (CW+1)'(1) - (CW+1)'(w_rel);
      end else begin
        if (i_rename_en && !w_stall) begin
          for (int i = 0; i < int'(RW); i++) begin
            if (i_rd_valid[i]) begin
              w_src_nxt[i_alloc_preg[i]]   = i_rd[i];
              w_valid_nxt[i_alloc_preg[i]] = 1'b1;
              w_valid_nxt[o_pprd[i]]       = 1'b0;
            end
            // snapshot sees slots 0..i only
            if (i_ckpt_req[i]) begin
              w_snap_nxt[r_tail] = w_valid_nxt;
              w_alloc            = 1'b1;
            end
          end
        end
        if (w_alloc) w_tail_nxt = ptr_inc(r_tail);
        w_count_nxt = r_count + (CW+1)'(w_alloc) - (CW+1)'(w_rel);
      end
      if (w_rel) w_head_nxt = ptr_inc(r_head);
    end
  end

  // State registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_src   <= '0;
      r_valid <= '0;
      r_snap  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_src   <= w_src_nxt;
      r_valid <= w_valid_nxt;
      r_snap  <= w_snap_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule
